// File: rtl/heater_controller_pkg.sv
// heater_controller_pkg: shared washer state encoding, temperature defaults and band helper
package heater_controller_pkg;
  typedef enum logic [1:0] {IDLE, HEATING, HOLD, FAULT} state_t;
  localparam int MAX_TEMP_DEFAULT = 95;
  localparam int HYST_DEFAULT = 2;
  function automatic logic [6:0] low_band(input logic [6:0] t, input int h);
    return (int'(t) > h) ? 7'(int'(t) - h) : 7'd0;
  endfunction
endpackage

// File: rtl/heater_controller_if.sv
// heater_controller_if: control/sensor inputs and heater status outputs of the heater controller
interface heater_controller_if;
  logic start;
  logic abort;
  logic [6:0] target_temperature;
  logic [6:0] measured_temperature;
  logic heater_on;
  logic temp_reached;
  logic busy;
  logic fault;
  modport master(output start, abort, target_temperature, measured_temperature,
                 input heater_on, temp_reached, busy, fault);
  modport slave(input start, abort, target_temperature, measured_temperature,
                output heater_on, temp_reached, busy, fault);
endinterface

// File: rtl/heater_controller_edge.sv
// rising_edge_detect: one-cycle request on a 0->1 transition of a synchronous level
module rising_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;
  logic armed;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q <= d;
      armed <= 1'b1;
    end
  // a level already high when reset releases is not an edge
  assign rise = armed & d & ~d_q;
endmodule

// File: rtl/heater_controller.sv
// heater_controller: heat-to-target then hold-with-hysteresis FSM with timeout and over-temp trip
module heater_controller
  import heater_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HYST = HYST_DEFAULT,
  parameter int MAX_TEMP = MAX_TEMP_DEFAULT
) (
  input logic clk,
  input logic reset,
  heater_controller_if.slave bus
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  state_t state;
  logic [6:0] target_q;
  logic [CW-1:0] cnt;
  logic req, over, at_target, below, tmo;
  logic heater_on, temp_reached, busy, fault;
  rising_edge_detect u_edge (.clk(clk), .reset(reset), .d(bus.start), .rise(req));
  assign over = int'(bus.measured_temperature) > MAX_TEMP;
  assign at_target = bus.measured_temperature >= target_q;
  assign below = bus.measured_temperature < low_band(target_q, HYST);
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      target_q <= '0;
      cnt <= '0;
      heater_on <= 1'b0;
      temp_reached <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
    end else if (over) begin
      state <= FAULT;
      heater_on <= 1'b0;
      temp_reached <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b1;
    end else case (state)
      IDLE: if (req && !bus.abort) begin
        state <= HEATING;
        target_q <= bus.target_temperature;
        cnt <= '0;
        heater_on <= 1'b1;
        busy <= 1'b1;
      end
      HEATING: if (bus.abort) begin
        state <= IDLE;
        heater_on <= 1'b0;
        busy <= 1'b0;
      end else if (tmo) begin
        state <= FAULT;
        heater_on <= 1'b0;
        busy <= 1'b0;
        fault <= 1'b1;
      end else if (at_target) begin
        state <= HOLD;
        heater_on <= 1'b0;
        temp_reached <= 1'b1;
      end else
        cnt <= cnt + CW'(1);
      HOLD: if (bus.abort || !bus.start) begin
        state <= IDLE;
        heater_on <= 1'b0;
        temp_reached <= 1'b0;
        busy <= 1'b0;
      end else
        heater_on <= below ? 1'b1 : at_target ? 1'b0 : heater_on;
      FAULT: if (bus.abort) begin
        state <= IDLE;
        fault <= 1'b0;
      end
      default: state <= IDLE;
    endcase
  assign bus.heater_on = heater_on;
  assign bus.temp_reached = temp_reached;
  assign bus.busy = busy;
  assign bus.fault = fault;
endmodule

// File: doc/heater_controller.md
HEATER_CONTROLLER -- requirements
Module: heater_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum clk cycles allowed in HEATING.
REQ-003 Parameter HYST, default 2: hold-band hysteresis in degrees C.
REQ-004 Parameter MAX_TEMP, default 95: over-temperature trip level in degrees C.
REQ-005 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  level from the control FSM; its rising edge requests a heat cycle.
REQ-008 abort  input  1  level; ends any cycle and clears a fault.
REQ-009 target_temperature  input  7  selected wash temperature from the temperature selector; unsigned degrees C.
REQ-010 measured_temperature  input  7  drum sensor reading; unsigned degrees C; already synchronous to clk.
REQ-011 heater_on  output  1  heater relay drive.
REQ-012 temp_reached  output  1  level; high while in HOLD.
REQ-013 busy  output  1  high in HEATING or HOLD.
REQ-014 fault  output  1  high in FAULT.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, HEATING, HOLD and FAULT.
REQ-016 The state and all outputs SHALL be registered; each output SHALL reflect the conditions sampled on the previous rising clk edge.
REQ-017 Start edge detection SHALL use a one-cycle delayed copy of start; a request is start=1 with the previous sample 0.
REQ-018 In IDLE, a request SHALL latch target_temperature into an internal 7-bit target_q and move the FSM to HEATING.
- target_temperature SHALL be ignored at all other times.
REQ-019 In HEATING, heater_on SHALL be 1.
- When measured_temperature >= target_q, the FSM SHALL move to HOLD.
REQ-020 If the request arrives while measured_temperature >= target_temperature (e.g. a 10 C cold wash), the FSM SHALL pass through HEATING for one cycle and then enter HOLD.
REQ-021 A 10-bit-minimum timeout counter SHALL clear on entry to HEATING and increment each cycle spent in HEATING.
- When it reaches TIMEOUT_CYCLES, the FSM SHALL move to FAULT.
REQ-022 In HOLD, the heater SHALL follow this hysteresis rule:
- heater_on SHALL go to 1 when measured_temperature < low_band;
- heater_on SHALL go to 0 when measured_temperature >= target_q;
- otherwise heater_on SHALL keep its previous value.
REQ-023 low_band SHALL be target_q - HYST, saturating at 0 with no wrap-around.
REQ-024 In HOLD, a low level on start SHALL return the FSM to IDLE, and temp_reached SHALL fall with that transition.
REQ-025 From any state, measured_temperature > MAX_TEMP SHALL force FAULT with heater_on=0.
- This rule SHALL have the highest priority.
REQ-026 From HEATING or HOLD, abort=1 SHALL return the FSM to IDLE with heater_on=0.
REQ-027 FAULT SHALL persist until abort=1 and measured_temperature <= MAX_TEMP, and SHALL then exit to IDLE.
REQ-028 When multiple events occur in the same cycle, priority SHALL be: over-temperature, then abort, then timeout, then temperature compare, then start.
REQ-029 heater_on SHALL be 0 in IDLE and FAULT in all cases.

Reset
REQ-030 While reset is asserted, the block SHALL hold: state IDLE, heater_on=0, temp_reached=0, busy=0, fault=0, target_q=0, timeout counter 0, start delay register 0.
REQ-031 Reset asserted mid-cycle SHALL drop heater_on asynchronously.
REQ-032 If start is high when reset is released, that level SHALL NOT count as a request; a fresh rising edge is required.

Structure
REQ-033 The state encoding constants and the default values of MAX_TEMP and HYST SHALL live in the shared washer package.
REQ-034 The start edge detector SHALL be implemented as the sub-module rising_edge_detect, for reuse by the control FSM.

Verification
REQ-035 Target 40, measured 25 rising by 1 every 10 cycles, start pulse -> heater_on=1 until measured=40, then HOLD with temp_reached=1 and heater_on=0.
REQ-036 In HOLD with target 40, measured falls to 38 -> heater_on stays 0; measured falls to 37 -> heater_on=1; measured back at 40 -> heater_on=0.
REQ-037 Target 60, measured stuck at 30, TIMEOUT_CYCLES=1000 -> FAULT with fault=1 and heater_on=0 exactly 1000 cycles after HEATING entry; abort -> IDLE.
REQ-038 Target 10, measured 20, start -> HOLD after 2 cycles with no heater activity beyond 1 cycle; measured 96 in HOLD -> FAULT on the next edge.
REQ-039 Reset asserted during HEATING with start held high -> outputs 0 immediately; after release, no HEATING until start goes 0 then 1.
REQ-040 abort and over-temperature asserted in the same cycle during HEATING -> the FSM SHALL end in FAULT, not IDLE.
